// File: rtl/step_counter_pkg.sv
// Shared encodings for the parity step counter and its step calculator.
package step_counter_pkg;
    typedef enum logic [1:0] {
        MODE_EVEN_A = 2'b00,
        MODE_ODD_A  = 2'b01,
        MODE_FIXED  = 2'b10,
        MODE_UNIT   = 2'b11
    } mode_e;
endpackage

// File: rtl/step_calc.sv
// Combinational next-count calculator: picks a parity-dependent step and applies it
// up or down, flagging carry/borrow and optionally clamping at the range ends.
import step_counter_pkg::*;

module step_calc #(
    parameter int WIDTH  = 8,
    parameter int STEP_A = 2,
    parameter int STEP_B = 3
) (
    input  logic [WIDTH-1:0] i_dout,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_next,
    output logic             o_ovf
);
    localparam logic [WIDTH:0] W_A = (WIDTH+1)'(STEP_A);
    localparam logic [WIDTH:0] W_B = (WIDTH+1)'(STEP_B);

    logic [WIDTH:0] w_step;
    logic [WIDTH:0] w_sum;
    logic           w_odd;

    assign w_odd = i_dout[0];

    always_comb begin
        w_step = W_A;
        case (mode_e'(i_mode))
            MODE_EVEN_A: w_step = w_odd ? W_B : W_A;
            MODE_ODD_A:  w_step = w_odd ? W_A : W_B;
            MODE_FIXED:  w_step = W_A;
            MODE_UNIT:   w_step = (WIDTH+1)'(1);
            default:     w_step = W_A;
        endcase
    end

    // The extra top bit is the carry going up and the borrow going down.
    always_comb begin
        w_sum  = i_dir ? ({1'b0, i_dout} - w_step) : ({1'b0, i_dout} + w_step);
        o_ovf  = w_sum[WIDTH];
        o_next = w_sum[WIDTH-1:0];
        if (o_ovf && i_sat)
            o_next = i_dir ? '0 : '1;
    end
endmodule

// File: rtl/parity_step_counter.sv
// Step counter with parity-selected step sizes, up/down, wrap/saturate and
// overflow pulse/sticky flags. Holds the registers and load/enable priority.
import step_counter_pkg::*;

module parity_step_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_A = 2,
    parameter int STEP_B = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic             i_sat,
    input  logic             i_clr_ovf,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_ovf_pulse,
    output logic             o_ovf_sticky,
    output logic             o_at_limit
);
    localparam longint MAXV = (64'd1 << WIDTH) - 1;

    if (STEP_A < 1 || longint'(STEP_A) > MAXV) begin : g_bad_step_a
        $error("STEP_A out of range 1..MAXV");
    end
    if (STEP_B < 1 || longint'(STEP_B) > MAXV) begin : g_bad_step_b
        $error("STEP_B out of range 1..MAXV");
    end

    logic [WIDTH-1:0] r_dout;
    logic             r_ovf_pulse;
    logic             r_ovf_sticky;
    logic [WIDTH-1:0] w_next;
    logic             w_ovf;
    logic             w_step_ovf;

    step_calc #(.WIDTH(WIDTH), .STEP_A(STEP_A), .STEP_B(STEP_B)) u_calc (
        .i_dout (r_dout),
        .i_mode (i_mode),
        .i_dir  (i_dir),
        .i_sat  (i_sat),
        .o_next (w_next),
        .o_ovf  (w_ovf)
    );

    // Only an enabled, non-load step can raise the overflow flags.
    assign w_step_ovf = i_en && !i_load && w_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_ovf_pulse  <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else begin
            if (i_load)
                r_dout <= i_din;
            else if (i_en)
                r_dout <= w_next;
            r_ovf_pulse <= w_step_ovf;
            // Set beats clear when both land on the same edge.
            if (w_step_ovf)
                r_ovf_sticky <= 1'b1;
            else if (i_clr_ovf)
                r_ovf_sticky <= 1'b0;
        end
    end

    assign o_dout       = r_dout;
    assign o_ovf_pulse  = r_ovf_pulse;
    assign o_ovf_sticky = r_ovf_sticky;
    assign o_at_limit   = i_dir ? (r_dout == '0) : (r_dout == '1);
endmodule

// File: tb/tb_parity_step_counter.sv
// Directed bench for parity_step_counter at WIDTH=4, STEP_A=2, STEP_B=3.
module tb_parity_step_counter;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [1:0]       mode;
    logic             dir;
    logic             sat;
    logic             clr_ovf;
    logic [WIDTH-1:0] dout;
    logic             ovf_pulse;
    logic             ovf_sticky;
    logic             at_limit;

    int checks = 0;
    int errors = 0;

    parity_step_counter #(.WIDTH(WIDTH), .STEP_A(2), .STEP_B(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .i_load       (load),
        .i_din        (din),
        .i_mode       (mode),
        .i_dir        (dir),
        .i_sat        (sat),
        .i_clr_ovf    (clr_ovf),
        .o_dout       (dout),
        .o_ovf_pulse  (ovf_pulse),
        .o_ovf_sticky (ovf_sticky),
        .o_at_limit   (at_limit)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1; en = 1'b0; din = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; load = 1'b0; din = '0;
        mode = 2'b00; dir = 1'b0; sat = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (dout !== 4'd0 || ovf_pulse !== 1'b0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset: dout=%0d pulse=%0b sticky=%0b, want 0/0/0", dout, ovf_pulse, ovf_sticky);
        end
    endtask

    task automatic test_even_up;
        int exp_v[4] = '{6, 8, 10, 12};
        mode = 2'b00; dir = 1'b0; sat = 1'b0;
        do_load(4'd4);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dout !== 4'(exp_v[i]) || ovf_pulse !== 1'b0) begin
                errors++;
                $display("FAIL even_up[%0d]: dout=%0d pulse=%0b, want %0d/0", i, dout, ovf_pulse, exp_v[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_odd_wrap;
        int exp_v[6]   = '{7, 9, 11, 13, 15, 1};
        bit exp_p[6]   = '{0, 0, 0, 0, 0, 1};
        mode = 2'b01; dir = 1'b0; sat = 1'b0;
        do_load(4'd5);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (dout !== 4'(exp_v[i]) || ovf_pulse !== exp_p[i]) begin
                errors++;
                $display("FAIL odd_wrap[%0d]: dout=%0d pulse=%0b, want %0d/%0b", i, dout, ovf_pulse, exp_v[i], exp_p[i]);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (ovf_sticky !== 1'b1 || ovf_pulse !== 1'b0) begin
            errors++;
            $display("FAIL odd_wrap_sticky: sticky=%0b pulse=%0b, want 1/0", ovf_sticky, ovf_pulse);
        end
    endtask

    task automatic test_sat_up;
        mode = 2'b00; dir = 1'b0; sat = 1'b1;
        do_load(4'd14);
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dout !== 4'd15 || ovf_pulse !== 1'b1 || at_limit !== 1'b1) begin
                errors++;
                $display("FAIL sat_up[%0d]: dout=%0d pulse=%0b lim=%0b, want 15/1/1", i, dout, ovf_pulse, at_limit);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down;
        mode = 2'b10; dir = 1'b1; sat = 1'b0;
        do_load(4'd3);
        en = 1'b1;
        tick();
        checks++;
        if (dout !== 4'd1 || ovf_pulse !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap0: dout=%0d pulse=%0b, want 1/0", dout, ovf_pulse);
        end
        tick();
        checks++;
        if (dout !== 4'd15 || ovf_pulse !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap1: dout=%0d pulse=%0b, want 15/1", dout, ovf_pulse);
        end
        sat = 1'b1;
        do_load(4'd3);
        en = 1'b1;
        tick();
        checks++;
        if (dout !== 4'd1 || ovf_pulse !== 1'b0 || at_limit !== 1'b0) begin
            errors++;
            $display("FAIL down_sat0: dout=%0d pulse=%0b lim=%0b, want 1/0/0", dout, ovf_pulse, at_limit);
        end
        tick();
        checks++;
        if (dout !== 4'd0 || ovf_pulse !== 1'b1 || at_limit !== 1'b1) begin
            errors++;
            $display("FAIL down_sat1: dout=%0d pulse=%0b lim=%0b, want 0/1/1", dout, ovf_pulse, at_limit);
        end
        en = 1'b0; sat = 1'b0; dir = 1'b0;
    endtask

    task automatic test_load_clr;
        mode = 2'b11; dir = 1'b0; sat = 1'b0;
        load = 1'b1; en = 1'b1; din = 4'd9;
        tick();
        load = 1'b0; en = 1'b0;
        checks++;
        if (dout !== 4'd9 || ovf_pulse !== 1'b0) begin
            errors++;
            $display("FAIL load_over_en: dout=%0d pulse=%0b, want 9/0", dout, ovf_pulse);
        end
        do_load(4'd15);
        en = 1'b1; clr_ovf = 1'b1;
        tick();
        checks++;
        if (dout !== 4'd0 || ovf_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set: dout=%0d pulse=%0b sticky=%0b, want 0/1/1", dout, ovf_pulse, ovf_sticky);
        end
        en = 1'b0;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0 || dout !== 4'd0) begin
            errors++;
            $display("FAIL clr_alone: sticky=%0b dout=%0d, want 0/0", ovf_sticky, dout);
        end
    endtask

    task automatic test_reset_mid;
        mode = 2'b11; dir = 1'b0; sat = 1'b0;
        do_load(4'd14);
        en = 1'b1;
        tick(); tick();
        // 14 -> 15 -> 0 with carry, so sticky and pulse are both set here
        load = 1'b1; din = 4'd11; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        checks++;
        if (dout !== 4'd11 || ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: dout=%0d sticky=%0b, want 11/1", dout, ovf_sticky);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        checks++;
        if (dout !== 4'd0 || ovf_pulse !== 1'b0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: dout=%0d pulse=%0b sticky=%0b, want 0/0/0", dout, ovf_pulse, ovf_sticky);
        end
    endtask

    task automatic test_hold;
        do_load(4'd7);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dout !== 4'd7 || ovf_pulse !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: dout=%0d pulse=%0b, want 7/0", i, dout, ovf_pulse);
            end
        end
    endtask

    task automatic test_mode_switch;
        mode = 2'b00; dir = 1'b0; sat = 1'b0;
        do_load(4'd4);
        en = 1'b1;
        tick();
        checks++;
        if (dout !== 4'd6) begin
            errors++;
            $display("FAIL mode_sw0: dout=%0d, want 6", dout);
        end
        mode = 2'b11;
        tick();
        checks++;
        if (dout !== 4'd7) begin
            errors++;
            $display("FAIL mode_sw1: dout=%0d, want 7", dout);
        end
        mode = 2'b00;
        tick();
        checks++;
        if (dout !== 4'd10) begin
            errors++;
            $display("FAIL mode_sw2: dout=%0d, want 10", dout);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_even_up();
        test_odd_wrap();
        test_sat_up();
        test_down();
        test_load_clr();
        test_reset_mid();
        test_hold();
        test_mode_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
